key_scan: RTL and testbench

- Input-side counterpart to the board LED driver: debounces the four active-low push buttons (KEY1~KEY4) on the 50 MHz board clock.
- Reports a clean level per key plus one-cycle press/release event pulses.
- Sits between the raw key pins and user logic, e.g. an LED pattern controller stepped by key presses.
- Channels are fully independent; one shared clock and reset.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_scan_if.sv | 26 ++
 rtl/key_debounce_ch.sv | 150 +++++++++++++++
 rtl/key_scan.sv | 40 ++++
 tb/tb_key_scan.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key_scan debouncer.
package key_pkg;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned DEBOUNCE_MS      = 20;
    localparam int unsigned LONG_MS          = 2000;
    localparam int unsigned DEBOUNCE_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_DEFAULT     = CLK_HZ / 1000 * LONG_MS;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } key_fsm_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_scan_if.sv
// Key pin / debounced-event bundle between the raw key pins, key_scan and user logic.
interface key_scan_if #(
    parameter int unsigned KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_n;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;

    modport master (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-flop synchronizer, debounce FSM and counter.
// Long-press detection is built only when KEY_SCAN_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned CntMax = max_u(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [1:0]      sync_q, sync_d;
    key_fsm_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_state_q, key_state_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            s;

    assign s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], key_n_i};
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!s) begin
                    state_d = StPressWait;
                    cnt_d   = CntOne;
                end
            end
            StPressWait: begin
                if (s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d     = StPressed;
                    key_state_d = 1'b1;
                    press_d     = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPressed: begin
                if (s) begin
                    state_d = StReleaseWait;
                    cnt_d   = CntOne;
                end
            end
            StReleaseWait: begin
                if (!s) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d     = StIdle;
                    key_state_d = 1'b0;
                    release_d   = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign state_o   = key_state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef KEY_SCAN_LONG_PRESS_EN
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);

    logic [CntW-1:0] hold_q, hold_d;
    logic            fired_q, fired_d;
    logic            long_q, long_d;

    // The fired flag survives release bounces; only a real release (IDLE) re-arms it.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (state_q == StIdle) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (state_q == StPressed && !s) begin
            if (hold_q != LongLast) begin
                hold_d = hold_q + CntOne;
            end else if (!fired_q) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_scan.sv
// Debouncer for KEY_NUM active-low push buttons; one independent channel per key.
// Optional long-press pulses are enabled by defining KEY_SCAN_LONG_PRESS_EN.
module key_scan
    import key_pkg::*;
#(
    parameter int unsigned KEY_NUM         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
    input logic        clk,
    input logic        rst_n,
    key_scan_if.slave  ks
);

    logic [KEY_NUM-1:0] state;
    logic [KEY_NUM-1:0] press;
    logic [KEY_NUM-1:0] rel;
    logic [KEY_NUM-1:0] lng;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_n_i   (ks.key_n[i]),
            .state_o   (state[i]),
            .press_o   (press[i]),
            .release_o (rel[i]),
            .long_o    (lng[i])
        );
    end

    assign ks.key_state   = state;
    assign ks.key_press   = press;
    assign ks.key_release = rel;
    assign ks.key_long    = lng;

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: directed scenarios plus random bouncing keys,
// compared every cycle against a run-length debounce model.
module tb_key_scan;

    localparam int unsigned KN  = 4;
    localparam int          DEB = 8;
    localparam int          LNG = 20;

    logic clk;
    logic rst_n;

    key_scan_if #(.KEY_NUM(KN)) ks ();

    key_scan #(
        .KEY_NUM         (KN),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (ks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model: a level flips once DEB consecutive synchronized samples disagree with it.
    bit              h1 [KN];
    bit              h2 [KN];
    bit              m_level [KN];
    int              m_run [KN];
    int              m_hold [KN];
    bit              m_fired [KN];
    logic [KN-1:0]   e_state, e_press, e_rel, e_long;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < KN; k++) begin
            h1[k] = 1'b1;
            h2[k] = 1'b1;
            m_level[k] = 1'b0;
            m_run[k] = 0;
            m_hold[k] = 0;
            m_fired[k] = 1'b0;
        end
        e_state = '0;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
    endtask

    task automatic model_edge(input logic [KN-1:0] kn);
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        for (int k = 0; k < KN; k++) begin
            bit s;
            bit lvl0;
            int run0;
            s     = h2[k];
            h2[k] = h1[k];
            h1[k] = kn[k];
            lvl0  = m_level[k];
            run0  = m_run[k];
            // Held cycles count only while pressed with no release pending.
            if (lvl0 && run0 == 0 && !s) begin
                if (m_hold[k] < LNG) m_hold[k]++;
                if (m_hold[k] == LNG && !m_fired[k]) begin
                    m_fired[k] = 1'b1;
`ifdef KEY_SCAN_LONG_PRESS_EN
                    e_long[k] = 1'b1;
`endif
                end
            end
            if (s == lvl0) m_run[k]++;
            else m_run[k] = 0;
            if (m_run[k] == DEB) begin
                m_run[k]   = 0;
                m_level[k] = !lvl0;
                if (m_level[k]) begin
                    e_press[k] = 1'b1;
                end else begin
                    e_rel[k]   = 1'b1;
                    m_hold[k]  = 0;
                    m_fired[k] = 1'b0;
                end
            end
            e_state[k] = m_level[k];
        end
    endtask

    // Called at a falling edge: drive pins, advance model, sample after the next rising edge.
    task automatic step(input logic [KN-1:0] kn);
        ks.key_n = kn;
        model_edge(kn);
        @(posedge clk);
        @(negedge clk);
        check("state", 32'(ks.key_state), 32'(e_state));
        check("press", 32'(ks.key_press), 32'(e_press));
        check("release", 32'(ks.key_release), 32'(e_rel));
        check("long", 32'(ks.key_long), 32'(e_long));
    endtask

    initial begin
        int first;
        int np;
        int nr;
        int nl;
        int p2;
        int p3;
        int l3;
        int dur [KN];
        bit val [KN];
        logic [KN-1:0] kn;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ks.key_n = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", 32'(ks.key_state), 32'h0);
        check("rst_press", 32'(ks.key_press), 32'h0);
        check("rst_release", 32'(ks.key_release), 32'h0);
        check("rst_long", 32'(ks.key_long), 32'h0);

        // Keys held low through reset release
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            step(4'b0000);
            if (first < 0 && ks.key_press == 4'hF) first = i - 1;
        end
        check("rst_hold_lat", first, 9);
        check("rst_hold_state", 32'(ks.key_state), 32'hF);
        repeat (12) step(4'b1111);

        // Clean press on key 0
        first = -1; np = 0; nr = 0;
        for (int i = 1; i <= 14; i++) begin
            step(4'b1110);
            if (ks.key_press[0]) begin
                np++;
                if (first < 0) first = i - 1;
            end
            if (ks.key_release[0]) nr++;
        end
        check("press_lat", first, 9);
        check("press_cnt", np, 1);
        check("press_norel", nr, 0);

        // Glitch on key 1
        np = 0;
        repeat (5) begin
            step(4'b1100);
            if (ks.key_press[1] || ks.key_release[1]) np++;
        end
        repeat (10) begin
            step(4'b1110);
            if (ks.key_press[1] || ks.key_release[1]) np++;
        end
        check("glitch_pulses", np, 0);
        check("glitch_state", 32'(ks.key_state[1]), 32'h0);

        // Bouncy release on key 0
        first = -1; nr = 0;
        repeat (3) begin
            step(4'b1111);
            if (ks.key_release[0]) nr++;
        end
        step(4'b1110);
        if (ks.key_release[0]) nr++;
        for (int i = 1; i <= 14; i++) begin
            step(4'b1111);
            if (ks.key_release[0]) begin
                nr++;
                if (first < 0) first = i - 1;
            end
        end
        check("bounce_lat", first, 9);
        check("bounce_cnt", nr, 1);

        // Keys 2 and 3 pressed together, then held for the long-press window
        p2 = -1; p3 = -1; l3 = -1; nl = 0;
        for (int i = 1; i <= 52; i++) begin
            step(4'b0011);
            if (p2 < 0 && ks.key_press[2]) p2 = i;
            if (p3 < 0 && ks.key_press[3]) p3 = i;
            if (ks.key_long[3]) begin
                nl++;
                if (l3 < 0) l3 = i;
            end
        end
        check("conc_same", p2, p3);
        check("conc_lat", p3 - 1, 9);
`ifdef KEY_SCAN_LONG_PRESS_EN
        check("long_cnt", nl, 1);
        check("long_lat", l3 - p3, 20);
`else
        check("long_cnt", nl, 0);
`endif
        repeat (15) step(4'b1111);

        // Reset while key 2 is mid-debounce and key 0 is pressed
        repeat (12) step(4'b1110);
        repeat (4) step(4'b1010);
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(ks.key_state), 32'h0);
        check("rst_mid_press", 32'(ks.key_press), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = -1; nr = 0;
        for (int i = 1; i <= 14; i++) begin
            step(4'b1010);
            if (first < 0 && ks.key_press[2]) first = i - 1;
            if (ks.key_release[0]) nr++;
        end
        check("rst_re_lat", first, 9);
        check("rst_no_rel", nr, 0);

        // Random bouncing on all keys
        for (int k = 0; k < KN; k++) begin
            dur[k] = 0;
            val[k] = 1'b1;
        end
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int k = 0; k < KN; k++) begin
                if (dur[k] == 0) begin
                    val[k] = 1'($urandom_range(0, 1));
                    dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                                         : int'($urandom_range(1, 12));
                end
                kn[k] = val[k];
                dur[k]--;
            end
            step(kn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
